reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 64 ++++++
 tb/tb_reg_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// 32 x 32-bit register file: one write port, two registered read ports, $sp preset on reset.
// Optional write-to-read bypass is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank #(
   parameter logic [31:0] SP_RESET = 32'd227
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write,
   input  logic [4:0]  write_reg,
   input  logic [31:0] write_data,
   input  logic [4:0]  read_reg_one,
   input  logic [4:0]  read_reg_two,
   output logic [31:0] read_data_one,
   output logic [31:0] read_data_two
);

   localparam int unsigned NUM_REGS = 32;
   localparam logic [4:0]  SP_INDEX = 5'd29;

   logic [31:0] regs [NUM_REGS];
   logic        write_en;
   logic [31:0] next_one;
   logic [31:0] next_two;

   assign write_en = reg_write && (write_reg != 5'd0);

   // NOTE: the storage array is reset like any other flop because $sp needs a
   // non-zero preset; this rules out mapping it onto a RAM macro.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == int'(SP_INDEX)) ? SP_RESET : 32'h0;
         end
      end else if (write_en) begin
         regs[write_reg] <= write_data;
      end
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      next_one = regs[read_reg_one];
      next_two = regs[read_reg_two];
`ifdef REG_BANK_BYPASS_EN
      if (write_en && (write_reg == read_reg_one)) next_one = write_data;
      if (write_en && (write_reg == read_reg_two)) next_two = write_data;
`endif
      if (read_reg_one == 5'd0) next_one = 32'h0;
      if (read_reg_two == 5'd0) next_two = 32'h0;
   end

   // NOTE: non-blocking assignments keep both read ports sampling the array
   // as it stood before this edge's write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data_one <= 32'h0;
         read_data_two <= 32'h0;
      end else begin
         read_data_one <= next_one;
         read_data_two <= next_two;
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank; expectations follow the REG_BANK_BYPASS_EN build setting.
module tb_reg_bank;

   logic        clk;
   logic        reset;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  read_reg_one;
   logic [4:0]  read_reg_two;
   logic [31:0] read_data_one;
   logic [31:0] read_data_two;

   int compared   = 0;
   int mismatched = 0;

   reg_bank #(.SP_RESET(32'd227)) dut (
      .clk           (clk),
      .reset         (reset),
      .reg_write     (reg_write),
      .write_reg     (write_reg),
      .write_data    (write_data),
      .read_reg_one  (read_reg_one),
      .read_reg_two  (read_reg_two),
      .read_data_one (read_data_one),
      .read_data_two (read_data_two)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
      reg_write    = we;
      write_reg    = wr;
      write_data   = wd;
      read_reg_one = r1;
      read_reg_two = r2;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
      #1;
      check("reset_one_t0", read_data_one, 32'h0);
      check("reset_two_t0", read_data_two, 32'h0);
      tick();
      check("reset_one_clk", read_data_one, 32'h0);
      check("reset_two_clk", read_data_two, 32'h0);

      reset = 1'b1;
      tick();
      check("sp_after_reset", read_data_one, 32'd227);
      check("r5_after_reset", read_data_two, 32'h0);

      // Write then read back on both ports.
      drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd29, 5'd5);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
      tick();
      check("r8_port_one", read_data_one, 32'hDEADBEEF);
      check("r8_port_two", read_data_two, 32'hDEADBEEF);

      // Writes to index 0 are discarded, even when read on the same edge.
      drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
      tick();
      check("r0_same_edge", read_data_one, 32'h0);
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      check("r0_one", read_data_one, 32'h0);
      check("r0_two", read_data_two, 32'h0);

      // Same-edge read/write collision on index 9.
      drive(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
      tick();
      drive(1'b1, 5'd9, 32'h2, 5'd9, 5'd8);
      tick();
`ifdef REG_BANK_BYPASS_EN
      check("r9_collision", read_data_one, 32'h2);
`else
      check("r9_collision", read_data_one, 32'h1);
`endif
      check("r8_untouched", read_data_two, 32'hDEADBEEF);
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      tick();
      check("r9_next_one", read_data_one, 32'h2);
      check("r9_next_two", read_data_two, 32'h2);

      // Index 31 behaves normally; reg_write=0 leaves it alone.
      drive(1'b1, 5'd31, 32'hCAFE0031, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
      tick();
      check("r31_one", read_data_one, 32'hCAFE0031);
      check("r31_two", read_data_two, 32'hCAFE0031);

      // Populate 5 and 29 so the mid-run reset has something to clear.
      drive(1'b1, 5'd5, 32'h55, 5'd0, 5'd0);
      tick();
      drive(1'b1, 5'd29, 32'h1000, 5'd5, 5'd0);
      tick();
      check("r5_written", read_data_one, 32'h55);
      drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
      tick();
      check("sp_written", read_data_one, 32'h1000);
      check("r5_held", read_data_two, 32'h55);

      // Mid-run reset clears outputs asynchronously.
      reset = 1'b0;
      #1;
      check("midreset_one_async", read_data_one, 32'h0);
      check("midreset_two_async", read_data_two, 32'h0);
      tick();
      check("midreset_one_clk", read_data_one, 32'h0);
      check("midreset_two_clk", read_data_two, 32'h0);
      reset = 1'b1;
      tick();
      check("midreset_sp", read_data_one, 32'd227);
      check("midreset_r5", read_data_two, 32'h0);

      // Reset dropped on the same edge as a write: the write is lost.
      drive(1'b1, 5'd4, 32'h0000AAAA, 5'd4, 5'd9);
      @(posedge clk);
      reset = 1'b0;
      #1;
      check("collide_reset_out", read_data_one, 32'h0);
      drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd29);
      #3;
      reset = 1'b1;
      tick();
      check("r4_write_lost", read_data_one, 32'h0);
      check("sp_after_collide", read_data_two, 32'd227);
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
      tick();
      check("r9_cleared", read_data_one, 32'h0);
      check("r31_cleared", read_data_two, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
